axis_video_tx: RTL and testbench
================================

Name: axis_video_tx

Overview:
Converts a raw timing-based pixel stream (data, data-enable, vsync) into an AXIS4 video stream whose framing matches what the delta filter and other stream consumers expect: tUser on the first pixel of a frame, tLast on the last pixel of each line. It is the transmit end of the pipeline's AXIS video interface and sits between the camera/timing front end and the filters. A small FIFO absorbs downstream backpressure. Overflow is flagged and the block re-locks to the next frame start.

Parameters:
DATA_W, 8, pixel width in bits
FIFO_DEPTH, 16, FIFO entries; power of two, >= 4

Ports:
clk  in  1  system clock; all logic on rising edge
reset  in  1  synchronous, active-low reset
vid_data  in  DATA_W  pixel data, qualified by vid_de
vid_de  in  1  high for each active pixel; one pixel per clk
vid_vsync  in  1  high (>=1 cycle) during vertical blanking; marks the start of a new frame
AXIS_Out_tData  out  DATA_W  pixel
AXIS_Out_tValid  out  1  beat valid
AXIS_Out_tReady  in  1  downstream ready
AXIS_Out_tUser  out  1  start of frame (first pixel)
AXIS_Out_tLast  out  1  end of line (last pixel of line)
overflow  out  1  sticky; set when a pixel is lost
frame_count  out  16  number of SOF beats written to FIFO; wraps 0xFFFF->0

Behaviour:
- Reset (reset==0 at clk edge): FIFO emptied; hold stage cleared; state=SEARCH; sof_pending=0; all outputs 0 (tValid, tUser, tLast, tData, overflow, frame_count).
- State machine, two states:
  - SEARCH: pixels are discarded. vid_vsync==1 -> RUN with sof_pending=1.
  - RUN: pixels are captured.
  - Any FIFO overflow in RUN -> SEARCH and sof_pending=0.
- Hold stage, needed because tLast is only known when vid_de falls:
  - Cycle N, RUN and vid_de=1: hold_data<=vid_data, hold_sof<=sof_pending, hold_valid<=1. sof_pending is then cleared unless vid_vsync=1 the same cycle.
  - Cycle N+1, if hold_valid: push {hold_data, user=hold_sof, last=!vid_de}. If vid_de=0 that cycle, hold_valid<=0.
- vid_vsync and vid_de in the same cycle: the pixel takes the old sof_pending. sof_pending is set to 1 afterwards, so the next captured pixel carries tUser.
- A held pixel is still pushed after a transition out of RUN, unless the transition was caused by overflow of that same push.
- FIFO:
  - Synchronous, first-word-fall-through, FIFO_DEPTH entries, width DATA_W+2.
  - Pop when tValid&&tReady.
  - Push when full is allowed only if a pop occurs the same cycle.
  - Push when full without a pop: word dropped, overflow<=1 (held until reset), state->SEARCH.
- frame_count increments on each successful push with user=1.
- Output:
  - AXIS outputs are registered.
  - Latency: pixel sampled at cycle N appears on AXIS_Out at cycle N+2 when the FIFO is empty and tReady=1.
  - Once tValid=1, tData/tUser/tLast are held stable until tReady=1.
  - tValid never drops without a handshake.
  - Throughput is 1 beat/clk under continuous tReady.
- Wrap-around: FIFO pointers use log2(FIFO_DEPTH)+1 bits; full and empty are distinguished by the MSB.
- Words already in the FIFO at an overflow drain normally. The partial frame is not patched; downstream re-syncs on the next tUser.
- Reset mid-frame: every in-flight beat is discarded immediately and tValid=0 on the next cycle. Output resumes only after the next vsync.

Decomposition:
- Shared package (axis_video_pkg):
  - state enum {SEARCH, RUN}
  - FIFO word field positions: USER_BIT=DATA_W, LAST_BIT=DATA_W+1
  - default DATA_W
- One sub-module: axis_sync_fifo (parameters WIDTH, DEPTH; ports push/pop/din/dout/full/empty; same clk and active-low synchronous reset). The top holds the FSM, hold stage, counters and output register.

Test Plan:
1. Reset, then vsync, then a 2-line x 4-pixel frame (data 0x10..0x17), tReady=1. Expect 8 beats in order, first tValid 2 cycles after the first de. tUser=1 on 0x10 only; tLast=1 on 0x13 and 0x17; frame_count=1.
2. After reset, 4 pixels with de and no prior vsync. Expect no tValid and frame_count=0. Then vsync plus 4 pixels: expect 4 beats, first with tUser.
3. Same frame as 1, tReady=0 for 5 cycles during line 1. Expect tData/tUser/tLast held stable while stalled, all 8 beats delivered in order, overflow=0.
4. tReady=0 and one 20-pixel line, FIFO_DEPTH=16. Expect exactly 16 beats buffered, overflow=1, pixels 17-20 dropped. After tReady=1: 16 beats drain. Next vsync plus frame: new frame starts with tUser; overflow stays 1 until reset.
5. vsync asserted in the same cycle as the last pixel of a frame. That pixel gets tUser=0, tLast=1; the next frame's first pixel gets tUser=1.
6. Reset asserted mid-line with 5 beats queued. Next cycle tValid=0 and overflow=0, frame_count=0. No output until a new vsync.

Source files
------------

// File: rtl/axis_video_pkg.sv
// Shared types and FIFO word layout for the AXIS video transmit path.
// A FIFO word is {last, user, data[DATA_W-1:0]}.
package axis_video_pkg;

  localparam int DEF_DATA_W = 8;
  localparam int USER_BIT   = DEF_DATA_W;
  localparam int LAST_BIT   = DEF_DATA_W + 1;

  typedef enum logic {
    SEARCH = 1'b0,
    RUN    = 1'b1
  } state_e;

  function automatic int user_bit(input int data_w);
    return data_w + (USER_BIT - DEF_DATA_W);
  endfunction

  function automatic int last_bit(input int data_w);
    return data_w + (LAST_BIT - DEF_DATA_W);
  endfunction

endpackage

// File: rtl/axis_sync_fifo.sv
// First-word-fall-through synchronous FIFO with one extra pointer bit for full/empty.
// Also exposes the entry behind the head so a registered output stage can run at full rate.
module axis_sync_fifo #(
  parameter int WIDTH = 10,
  parameter int DEPTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic [WIDTH-1:0] dout_nxt,
  output logic             full,
  output logic             empty,
  output logic             multi
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wr_q;
  logic [AW:0]      rd_q;
  logic [AW:0]      count;
  logic [AW-1:0]    rd_nxt_idx;
  logic             do_push;
  logic             do_pop;

  assign count      = wr_q - rd_q;
  assign full       = (count == (AW+1)'(DEPTH));
  assign empty      = (wr_q == rd_q);
  assign multi      = (count >= (AW+1)'(2));
  assign do_push    = push && (!full || pop);
  assign do_pop     = pop && !empty;
  assign rd_nxt_idx = rd_q[AW-1:0] + AW'(1);
  assign dout       = mem_q[rd_q[AW-1:0]];
  assign dout_nxt   = mem_q[rd_nxt_idx];

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_q[AW-1:0]] <= din;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      if (do_push) begin
        wr_q <= wr_q + (AW+1)'(1);
      end
      if (do_pop) begin
        rd_q <= rd_q + (AW+1)'(1);
      end
    end
  end

endmodule

// File: rtl/axis_video_tx.sv
// Timing-based pixel stream (data/de/vsync) to AXIS video with tUser on SOF and tLast on EOL.
// A one-pixel hold stage waits for de to fall so tLast is known before the word enters the FIFO.
module axis_video_tx
  import axis_video_pkg::*;
#(
  parameter int DATA_W     = DEF_DATA_W,
  parameter int FIFO_DEPTH = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] vid_data,
  input  logic              vid_de,
  input  logic              vid_vsync,
  output logic [DATA_W-1:0] AXIS_Out_tData,
  output logic              AXIS_Out_tValid,
  input  logic              AXIS_Out_tReady,
  output logic              AXIS_Out_tUser,
  output logic              AXIS_Out_tLast,
  output logic              overflow,
  output logic [15:0]       frame_count
);

  localparam int UB = user_bit(DATA_W);
  localparam int LB = last_bit(DATA_W);
  localparam int WW = DATA_W + 2;

  state_e            state_q;
  logic              sof_pending_q;
  logic              hold_valid_q;
  logic              hold_sof_q;
  logic [DATA_W-1:0] hold_data_q;
  logic              overflow_q;
  logic [15:0]       frame_count_q;
  logic              tvalid_q;
  logic [WW-1:0]     out_word_q;

  logic [WW-1:0]     push_word;
  logic [WW-1:0]     fifo_dout;
  logic [WW-1:0]     fifo_dout_nxt;
  logic              fifo_full;
  logic              fifo_empty;
  logic              fifo_multi;
  logic              fifo_pop;
  logic              drop;
  logic              capture;

  always_comb begin
    push_word                = '0;
    push_word[DATA_W-1:0]    = hold_data_q;
    push_word[UB]            = hold_sof_q;
    push_word[LB]            = ~vid_de;
  end

  assign fifo_pop = tvalid_q && AXIS_Out_tReady;
  assign drop     = hold_valid_q && fifo_full && !fifo_pop;
  assign capture  = (state_q == RUN) && vid_de && !drop;

  axis_sync_fifo #(
    .WIDTH (WW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .reset    (reset),
    .push     (hold_valid_q),
    .pop      (fifo_pop),
    .din      (push_word),
    .dout     (fifo_dout),
    .dout_nxt (fifo_dout_nxt),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .multi    (fifo_multi)
  );

  // Frame lock FSM, hold stage and status counters; an overflow drops the held pixel and re-locks.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q       <= SEARCH;
      sof_pending_q <= 1'b0;
      hold_valid_q  <= 1'b0;
      hold_sof_q    <= 1'b0;
      hold_data_q   <= '0;
      overflow_q    <= 1'b0;
      frame_count_q <= 16'd0;
    end else begin
      hold_valid_q <= capture;
      if (capture) begin
        hold_data_q <= vid_data;
        hold_sof_q  <= sof_pending_q;
      end
      if (drop) begin
        overflow_q <= 1'b1;
      end
      if (hold_valid_q && !drop && hold_sof_q) begin
        frame_count_q <= frame_count_q + 16'd1;
      end
      case (state_q)
        SEARCH: begin
          if (vid_vsync) begin
            state_q       <= RUN;
            sof_pending_q <= 1'b1;
          end
        end
        RUN: begin
          if (drop) begin
            state_q       <= SEARCH;
            sof_pending_q <= 1'b0;
          end else if (vid_vsync) begin
            sof_pending_q <= 1'b1;
          end else if (capture) begin
            sof_pending_q <= 1'b0;
          end
        end
        default: begin
          state_q       <= SEARCH;
          sof_pending_q <= 1'b0;
        end
      endcase
    end
  end

  // Output register mirrors the FIFO head; the head itself is popped only on handshake.
  always_ff @(posedge clk) begin
    if (!reset) begin
      tvalid_q   <= 1'b0;
      out_word_q <= '0;
    end else if (!tvalid_q || AXIS_Out_tReady) begin
      if (tvalid_q) begin
        tvalid_q <= fifo_multi;
        if (fifo_multi) begin
          out_word_q <= fifo_dout_nxt;
        end
      end else begin
        tvalid_q <= !fifo_empty;
        if (!fifo_empty) begin
          out_word_q <= fifo_dout;
        end
      end
    end
  end

  assign AXIS_Out_tValid = tvalid_q;
  assign AXIS_Out_tData  = out_word_q[DATA_W-1:0];
  assign AXIS_Out_tUser  = out_word_q[UB];
  assign AXIS_Out_tLast  = out_word_q[LB];
  assign overflow        = overflow_q;
  assign frame_count     = frame_count_q;

endmodule

// File: tb/tb_axis_video_tx.sv
// Directed bench for axis_video_tx: framing, latency, stall, overflow and reset recovery.
module tb_axis_video_tx;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  vid_data;
  logic        vid_de;
  logic        vid_vsync;
  logic [7:0]  tdata;
  logic        tvalid;
  logic        tready;
  logic        tuser;
  logic        tlast;
  logic        overflow;
  logic [15:0] frame_count;

  int pass_cnt = 0;
  int chk_cnt  = 0;
  logic [9:0] beats [$];

  always #5 clk = ~clk;

  axis_video_tx #(.DATA_W(8), .FIFO_DEPTH(16)) dut (
    .clk             (clk),
    .reset           (reset),
    .vid_data        (vid_data),
    .vid_de          (vid_de),
    .vid_vsync       (vid_vsync),
    .AXIS_Out_tData  (tdata),
    .AXIS_Out_tValid (tvalid),
    .AXIS_Out_tReady (tready),
    .AXIS_Out_tUser  (tuser),
    .AXIS_Out_tLast  (tlast),
    .overflow        (overflow),
    .frame_count     (frame_count)
  );

  // Record every handshaken beat as {last, user, data}.
  always @(negedge clk) begin
    if (reset && tvalid && tready) beats.push_back({tlast, tuser, tdata});
  end

  task automatic pix(input logic [7:0] d, input logic de, input logic vs);
    vid_data = d; vid_de = de; vid_vsync = vs;
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) pix(8'h00, 1'b0, 1'b0);
  endtask

  task automatic send_line(input logic [7:0] base, input int n);
    for (int i = 0; i < n; i++) pix(base + 8'(i), 1'b1, 1'b0);
  endtask

  task automatic do_reset;
    reset = 1'b0;
    idle(2);
    reset = 1'b1;
    beats.delete();
  endtask

  task automatic test_reset;
    tready = 1'b1;
    do_reset();
    chk_cnt++;
    if ({tvalid, tuser, tlast, tdata, overflow, frame_count} !== 28'd0)
      $display("FAIL reset_outputs got=%h exp=0", {tvalid, tuser, tlast, tdata, overflow, frame_count});
    else pass_cnt++;
  endtask

  task automatic test_basic_frame;
    logic [9:0] exp;
    do_reset();
    pix(8'h00, 1'b0, 1'b1);
    pix(8'h10, 1'b1, 1'b0);
    pix(8'h11, 1'b1, 1'b0);
    chk_cnt++;
    if (tvalid !== 1'b0) $display("FAIL t1_latency_early got=%b exp=0", tvalid);
    else pass_cnt++;
    pix(8'h12, 1'b1, 1'b0);
    chk_cnt++;
    if ({tvalid, tuser, tdata} !== {1'b1, 1'b1, 8'h10})
      $display("FAIL t1_latency_first got=%h exp=%h", {tvalid, tuser, tdata}, {1'b1, 1'b1, 8'h10});
    else pass_cnt++;
    pix(8'h13, 1'b1, 1'b0);
    idle(2);
    send_line(8'h14, 4);
    idle(8);
    chk_cnt++;
    if (beats.size() != 8) $display("FAIL t1_count got=%0d exp=8", beats.size());
    else pass_cnt++;
    for (int i = 0; i < 8; i++) begin
      exp = {(i == 3 || i == 7) ? 1'b1 : 1'b0, (i == 0) ? 1'b1 : 1'b0, 8'h10 + 8'(i)};
      chk_cnt++;
      if (i >= beats.size() || beats[i] !== exp)
        $display("FAIL t1_beat%0d got=%h exp=%h", i, (i < beats.size()) ? beats[i] : 10'hx, exp);
      else pass_cnt++;
    end
    chk_cnt++;
    if (frame_count !== 16'd1) $display("FAIL t1_frame_count got=%0d exp=1", frame_count);
    else pass_cnt++;
  endtask

  task automatic test_no_vsync;
    do_reset();
    send_line(8'h60, 4);
    idle(5);
    chk_cnt++;
    if (beats.size() != 0 || tvalid !== 1'b0 || frame_count !== 16'd0)
      $display("FAIL t2_discard got=%0d/%b/%0d exp=0/0/0", beats.size(), tvalid, frame_count);
    else pass_cnt++;
    pix(8'h00, 1'b0, 1'b1);
    send_line(8'h70, 4);
    idle(6);
    chk_cnt++;
    if (beats.size() != 4) $display("FAIL t2_count got=%0d exp=4", beats.size());
    else pass_cnt++;
    chk_cnt++;
    if (beats.size() < 4 || beats[0] !== 10'h170 || beats[3] !== 10'h273)
      $display("FAIL t2_framing got=%h,%h exp=170,273",
               (beats.size() > 0) ? beats[0] : 10'hx, (beats.size() > 3) ? beats[3] : 10'hx);
    else pass_cnt++;
  endtask

  task automatic test_stall;
    logic [7:0] d3 [12] = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h00, 8'h00,
                            8'h14, 8'h15, 8'h16, 8'h17, 8'h00, 8'h00};
    logic       e3 [12] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0,
                            1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    logic [10:0] snap;
    logic [9:0]  exp;
    do_reset();
    pix(8'h00, 1'b0, 1'b1);
    for (int k = 0; k < 12; k++) begin
      if (k == 3) snap = {tvalid, tlast, tuser, tdata};
      tready = (k >= 3 && k <= 7) ? 1'b0 : 1'b1;
      pix(d3[k], e3[k], 1'b0);
      if (k >= 3 && k <= 7) begin
        chk_cnt++;
        if ({tvalid, tlast, tuser, tdata} !== snap || snap !== 11'h510)
          $display("FAIL t3_stable_k%0d got=%h exp=510", k, {tvalid, tlast, tuser, tdata});
        else pass_cnt++;
      end
    end
    tready = 1'b1;
    idle(12);
    chk_cnt++;
    if (beats.size() != 8) $display("FAIL t3_count got=%0d exp=8", beats.size());
    else pass_cnt++;
    for (int i = 0; i < 8; i++) begin
      exp = {(i == 3 || i == 7) ? 1'b1 : 1'b0, (i == 0) ? 1'b1 : 1'b0, 8'h10 + 8'(i)};
      chk_cnt++;
      if (i >= beats.size() || beats[i] !== exp)
        $display("FAIL t3_beat%0d got=%h exp=%h", i, (i < beats.size()) ? beats[i] : 10'hx, exp);
      else pass_cnt++;
    end
    chk_cnt++;
    if (overflow !== 1'b0) $display("FAIL t3_overflow got=%b exp=0", overflow);
    else pass_cnt++;
  endtask

  task automatic test_vsync_last;
    logic [9:0] exp [8] = '{10'h130, 10'h031, 10'h032, 10'h233,
                            10'h140, 10'h041, 10'h042, 10'h243};
    do_reset();
    pix(8'h00, 1'b0, 1'b1);
    send_line(8'h30, 3);
    pix(8'h33, 1'b1, 1'b1);
    idle(2);
    send_line(8'h40, 4);
    idle(8);
    chk_cnt++;
    if (beats.size() != 8) $display("FAIL t5_count got=%0d exp=8", beats.size());
    else pass_cnt++;
    for (int i = 0; i < 8; i++) begin
      chk_cnt++;
      if (i >= beats.size() || beats[i] !== exp[i])
        $display("FAIL t5_beat%0d got=%h exp=%h", i, (i < beats.size()) ? beats[i] : 10'hx, exp[i]);
      else pass_cnt++;
    end
    chk_cnt++;
    if (frame_count !== 16'd2) $display("FAIL t5_frame_count got=%0d exp=2", frame_count);
    else pass_cnt++;
  endtask

  task automatic test_overflow;
    logic [9:0] exp;
    do_reset();
    tready = 1'b0;
    pix(8'h00, 1'b0, 1'b1);
    send_line(8'h20, 20);
    idle(3);
    chk_cnt++;
    if (overflow !== 1'b1 || frame_count !== 16'd1)
      $display("FAIL t4_overflow_set got=%b/%0d exp=1/1", overflow, frame_count);
    else pass_cnt++;
    tready = 1'b1;
    idle(24);
    chk_cnt++;
    if (beats.size() != 16) $display("FAIL t4_drain_count got=%0d exp=16", beats.size());
    else pass_cnt++;
    for (int i = 0; i < 16; i++) begin
      exp = {1'b0, (i == 0) ? 1'b1 : 1'b0, 8'h20 + 8'(i)};
      chk_cnt++;
      if (i >= beats.size() || beats[i] !== exp)
        $display("FAIL t4_beat%0d got=%h exp=%h", i, (i < beats.size()) ? beats[i] : 10'hx, exp);
      else pass_cnt++;
    end
    beats.delete();
    pix(8'h00, 1'b0, 1'b1);
    send_line(8'h80, 4);
    idle(6);
    chk_cnt++;
    if (beats.size() != 4 || beats[0] !== 10'h180 || beats[3] !== 10'h283)
      $display("FAIL t4_relock got=%0d beats first=%h exp=4 first=180",
               beats.size(), (beats.size() > 0) ? beats[0] : 10'hx);
    else pass_cnt++;
    chk_cnt++;
    if (overflow !== 1'b1 || frame_count !== 16'd2)
      $display("FAIL t4_sticky got=%b/%0d exp=1/2", overflow, frame_count);
    else pass_cnt++;
  endtask

  task automatic test_reset_mid;
    tready = 1'b0;
    pix(8'h00, 1'b0, 1'b1);
    send_line(8'h50, 6);
    chk_cnt++;
    if (tvalid !== 1'b1 || frame_count !== 16'd3 || overflow !== 1'b1)
      $display("FAIL t6_pre got=%b/%0d/%b exp=1/3/1", tvalid, frame_count, overflow);
    else pass_cnt++;
    reset = 1'b0;
    pix(8'h56, 1'b1, 1'b0);
    chk_cnt++;
    if (tvalid !== 1'b0 || overflow !== 1'b0 || frame_count !== 16'd0)
      $display("FAIL t6_cleared got=%b/%b/%0d exp=0/0/0", tvalid, overflow, frame_count);
    else pass_cnt++;
    reset = 1'b1;
    tready = 1'b1;
    beats.delete();
    send_line(8'h57, 4);
    idle(6);
    chk_cnt++;
    if (beats.size() != 0 || tvalid !== 1'b0)
      $display("FAIL t6_silent got=%0d/%b exp=0/0", beats.size(), tvalid);
    else pass_cnt++;
  endtask

  initial begin
    reset = 1'b0; vid_data = 8'h00; vid_de = 1'b0; vid_vsync = 1'b0; tready = 1'b1;
    test_reset();
    test_basic_frame();
    test_no_vsync();
    test_stall();
    test_vsync_last();
    test_overflow();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
